// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry front end.
package pin_entry_pkg;

  localparam int PKG_KEY_W = 4;

  typedef logic [PKG_KEY_W-1:0] key_t;

  // Scan codes for the two command keys; A, B, D and F carry no meaning.
  localparam key_t KEY_ENTER_DEF = 4'hE;
  localparam key_t KEY_CLEAR_DEF = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Scan codes 0..9 are decimal digit keys.
  function automatic logic is_digit(input key_t code);
    return (code <= key_t'(9));
  endfunction

endpackage

// File: rtl/pin_entry_key_edge_detect.sv
// Rising-edge detector for a level-held key strobe: one event per press.
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_evt
);

  logic r_level_q;

  // Remember last cycle's level so a held key only fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_q <= 1'b0;
    else        r_level_q <= i_level;
  end

  assign o_evt = i_level & ~r_level_q;

endmodule

// File: rtl/pin_entry.sv
// Two-digit PIN collector with valid/ack handoff to the gate controller.
module pin_entry
  import pin_entry_pkg::*;
#(
  parameter int              KEY_W          = 4,
  parameter int              NUM_DIGITS     = 2,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [KEY_W-1:0] KEY_ENTER     = KEY_W'(KEY_ENTER_DEF),
  parameter logic [KEY_W-1:0] KEY_CLEAR     = KEY_W'(KEY_CLEAR_DEF)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        key_valid,
  input  logic                        pw_ack,
  output logic [KEY_W*NUM_DIGITS-1:0] input_password,
  output logic                        pw_valid,
  output logic [1:0]                  digits_entered,
  output logic                        entry_error,
  output logic                        entry_timeout
);

  localparam int PW_W = KEY_W * NUM_DIGITS;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    FULL = 2'(NUM_DIGITS);

  state_t          r_state;
  logic [PW_W-1:0] r_pin_buf;
  logic [1:0]      r_count;
  logic [TW-1:0]   r_timer;

  logic w_key_evt;
  logic w_digit;
  logic w_enter;
  logic w_clear;

  key_edge_detect u_key_edge (
    .clk     (clk),
    .rst_n   (reset),
    .i_level (key_valid),
    .o_evt   (w_key_evt)
  );

  assign w_digit = w_key_evt & is_digit(key_t'(key_code));
  assign w_enter = w_key_evt & (key_code == KEY_ENTER);
  assign w_clear = w_key_evt & (key_code == KEY_CLEAR);

  assign digits_entered = r_count;

  // Entry FSM: digit shift register, idle timer and registered handshake/pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_pin_buf      <= '0;
      r_count        <= '0;
      r_timer        <= '0;
      input_password <= '0;
      pw_valid       <= 1'b0;
      entry_error    <= 1'b0;
      entry_timeout  <= 1'b0;
    end else begin
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_digit) begin
            r_pin_buf <= {r_pin_buf[PW_W-KEY_W-1:0], key_code};
            r_count   <= 2'd1;
            r_state   <= ENTRY;
          end else if (w_enter) begin
            entry_error <= 1'b1;
          end
        end
        ENTRY: begin
          // A key arriving on the expiry cycle takes priority over the timeout.
          if (w_digit) begin
            r_timer <= '0;
            if (r_count < FULL) begin
              r_pin_buf <= {r_pin_buf[PW_W-KEY_W-1:0], key_code};
              r_count   <= r_count + 2'd1;
            end
          end else if (w_enter) begin
            r_timer <= '0;
            if (r_count == FULL) begin
              input_password <= r_pin_buf;
              pw_valid       <= 1'b1;
              r_state        <= SEND;
            end else begin
              entry_error <= 1'b1;
              r_pin_buf   <= '0;
              r_count     <= '0;
              r_state     <= IDLE;
            end
          end else if (w_clear) begin
            r_timer   <= '0;
            r_pin_buf <= '0;
            r_count   <= '0;
            r_state   <= IDLE;
          end else if (r_timer == TMAX) begin
            entry_timeout <= 1'b1;
            r_timer       <= '0;
            r_pin_buf     <= '0;
            r_count       <= '0;
            r_state       <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        SEND: begin
          // Keys are dropped here; the PIN stays frozen until the controller takes it.
          r_timer <= '0;
          if (pw_ack) begin
            pw_valid  <= 1'b0;
            r_count   <= '0;
            r_pin_buf <= '0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry.sv
// Self-checking bench for pin_entry: scenario tasks plus a PIN scoreboard.
module tb_pin_entry;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid;
  logic       pw_ack;
  logic [7:0] input_password;
  logic       pw_valid;
  logic [1:0] digits_entered;
  logic       entry_error;
  logic       entry_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cycles = 0;
  int tmo_cycles = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_pin;
  logic       pv_prev = 1'b0;

  pin_entry #(
    .KEY_W          (4),
    .NUM_DIGITS     (2),
    .TIMEOUT_CYCLES (TMO),
    .KEY_ENTER      (4'hE),
    .KEY_CLEAR      (4'hC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .pw_ack         (pw_ack),
    .input_password (input_password),
    .pw_valid       (pw_valid),
    .digits_entered (digits_entered),
    .entry_error    (entry_error),
    .entry_timeout  (entry_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every rising pw_valid must present the next expected PIN.
  always @(negedge clk) begin
    if (entry_error)   err_cycles++;
    if (entry_timeout) tmo_cycles++;
    if (pw_valid && !pv_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got PIN %h, expected no submission", input_password);
      end else begin
        exp_pin = exp_q.pop_front();
        if (input_password !== exp_pin) begin
          n_fail++;
          $display("FAIL scoreboard_pin: got %h, expected %h", input_password, exp_pin);
        end
      end
    end
    pv_prev = pw_valid;
  end

  // One key press: held for 'hold' cycles, then released for one cycle.
  task automatic press(input logic [3:0] c, input int hold = 1);
    @(negedge clk);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    pw_ack = 1'b1;
    @(negedge clk);
    pw_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0; pw_ack = 1'b0;
    #12;
    n_checks++;
    if ({input_password, pw_valid, digits_entered, entry_error, entry_timeout} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: pw=%h valid=%b digits=%0d err=%b tmo=%b, expected all zero",
               input_password, pw_valid, digits_entered, entry_error, entry_timeout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_entry();
    int e0;
    e0 = err_cycles;
    press(4'h7);
    press(4'hE);
    @(negedge clk);
    n_checks++;
    if (err_cycles - e0 !== 1) begin
      n_fail++;
      $display("FAIL short_err_pulse: got %0d cycles, expected 1", err_cycles - e0);
    end
    n_checks++;
    if ({pw_valid, digits_entered, input_password} !== 11'h0) begin
      n_fail++;
      $display("FAIL short_state: valid=%b digits=%0d pw=%h, expected 0/0/00",
               pw_valid, digits_entered, input_password);
    end
  endtask

  task automatic test_basic();
    press(4'h1);
    n_checks++;
    if (digits_entered !== 2'd1) begin
      n_fail++; $display("FAIL basic_digits1: got %0d, expected 1", digits_entered);
    end
    press(4'h2);
    n_checks++;
    if (digits_entered !== 2'd2) begin
      n_fail++; $display("FAIL basic_digits2: got %0d, expected 2", digits_entered);
    end
    exp_q.push_back(8'h12);
    press(4'hE);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pw_valid !== 1'b1 || digits_entered !== 2'd2) begin
        n_fail++;
        $display("FAIL basic_hold: cycle %0d valid=%b digits=%0d, expected 1/2", i, pw_valid, digits_entered);
      end
    end
    do_ack();
    n_checks++;
    if (pw_valid !== 1'b0 || digits_entered !== 2'd0 || input_password !== 8'h12) begin
      n_fail++;
      $display("FAIL basic_after_ack: valid=%b digits=%0d pw=%h, expected 0/0/12",
               pw_valid, digits_entered, input_password);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int hit;
    t0  = tmo_cycles;
    hit = -1;
    press(4'h4);
    // The key edge was two cycles back, so expiry lands TMO-1 cycles from here.
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (entry_timeout && hit < 0) hit = i;
    end
    n_checks++;
    if (hit !== TMO - 1) begin
      n_fail++; $display("FAIL timeout_cycle: pulse at %0d, expected %0d", hit, TMO - 1);
    end
    n_checks++;
    if (tmo_cycles - t0 !== 1 || digits_entered !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_pulse: width %0d digits %0d, expected 1/0", tmo_cycles - t0, digits_entered);
    end
    press(4'h5); press(4'h6);
    exp_q.push_back(8'h56);
    press(4'hE);
    do_ack();
  endtask

  task automatic test_overflow_and_hold();
    press(4'h3); press(4'h9); press(4'h8);
    n_checks++;
    if (digits_entered !== 2'd2) begin
      n_fail++; $display("FAIL overflow_digits: got %0d, expected 2", digits_entered);
    end
    exp_q.push_back(8'h39);
    press(4'hE);
    n_checks++;
    if (input_password !== 8'h39) begin
      n_fail++; $display("FAIL overflow_pin: got %h, expected 39", input_password);
    end
    do_ack();
    press(4'h5, 10);
    n_checks++;
    if (digits_entered !== 2'd1) begin
      n_fail++; $display("FAIL hold_once: got %0d digits, expected 1", digits_entered);
    end
    press(4'hC);
    n_checks++;
    if (digits_entered !== 2'd0) begin
      n_fail++; $display("FAIL hold_clear: got %0d digits, expected 0", digits_entered);
    end
  endtask

  task automatic test_clear_and_send_lock();
    int e0;
    e0 = err_cycles;
    press(4'h2); press(4'hC); press(4'h8);
    press(4'hA);
    n_checks++;
    if (digits_entered !== 2'd1) begin
      n_fail++; $display("FAIL ignored_code: got %0d digits, expected 1", digits_entered);
    end
    press(4'h1);
    exp_q.push_back(8'h81);
    press(4'hE);
    press(4'h3); press(4'h4); press(4'hC);
    n_checks++;
    if (input_password !== 8'h81 || pw_valid !== 1'b1 || digits_entered !== 2'd2) begin
      n_fail++;
      $display("FAIL send_lock: pw=%h valid=%b digits=%0d, expected 81/1/2",
               input_password, pw_valid, digits_entered);
    end
    n_checks++;
    if (err_cycles !== e0) begin
      n_fail++; $display("FAIL clear_no_err: got %0d error cycles, expected 0", err_cycles - e0);
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    press(4'h9); press(4'h9);
    exp_q.push_back(8'h99);
    press(4'hE);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (pw_valid !== 1'b0 || input_password !== 8'h00 || digits_entered !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b pw=%h digits=%0d, expected 0/00/0",
               pw_valid, input_password, digits_entered);
    end
    @(negedge clk);
    reset = 1'b1;
    press(4'h4); press(4'h2);
    exp_q.push_back(8'h42);
    press(4'hE);
    n_checks++;
    if (pw_valid !== 1'b1 || input_password !== 8'h42) begin
      n_fail++; $display("FAIL post_reset_entry: valid=%b pw=%h, expected 1/42", pw_valid, input_password);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_short_entry();
    test_basic();
    test_timeout();
    test_overflow_and_hold();
    test_clear_and_send_lock();
    test_async_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d PINs never presented, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
